// File: rtl/commit_release_queue_pkg.sv
// Shared types and constants for the commit/release queue on the physical-tag free path.
package commit_release_queue_pkg;

  localparam int unsigned PHY_REG_SEL = 6;

  typedef enum logic {
    RQ_IDLE,
    RQ_RECOVER
  } rq_state_e;

endpackage

// File: rtl/commit_release_queue_rel_compact.sv
// Packs two optional released tags so the first valid one always lands in slot 1.
module rel_compact
  import commit_release_queue_pkg::*;
#(
  parameter int unsigned PTAG_W = PHY_REG_SEL
) (
  input  logic              a_val,
  input  logic [PTAG_W-1:0] a_tag,
  input  logic              b_val,
  input  logic [PTAG_W-1:0] b_tag,
  output logic [PTAG_W-1:0] tag1,
  output logic [PTAG_W-1:0] tag2,
  output logic              val1,
  output logic              val2,
  output logic [1:0]        relnum
);

  always_comb begin
    tag1 = '0;
    tag2 = '0;
    val1 = 1'b0;
    val2 = 1'b0;
    if (a_val) begin
      tag1 = a_tag;
      val1 = 1'b1;
      if (b_val) begin
        tag2 = b_tag;
        val2 = 1'b1;
      end
    end else if (b_val) begin
      tag1 = b_tag;
      val1 = 1'b1;
    end
    relnum = {1'b0, val1} + {1'b0, val2};
  end

endmodule

// File: rtl/commit_release_queue.sv
// Program-order log of {wr, old_tag, new_tag}: returns old tags at commit and,
// after a misprediction, walks squashed entries youngest-first returning new tags.
module commit_release_queue
  import commit_release_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PTAG_W = PHY_REG_SEL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_en1,
  input  logic              disp_en2,
  input  logic              disp_wr1,
  input  logic              disp_wr2,
  input  logic [PTAG_W-1:0] disp_old_tag1,
  input  logic [PTAG_W-1:0] disp_old_tag2,
  input  logic [PTAG_W-1:0] disp_new_tag1,
  input  logic [PTAG_W-1:0] disp_new_tag2,
  input  logic              stall_DP,
  input  logic [1:0]        comnum,
  input  logic              prmiss,
  output logic [PTAG_W-1:0] released_tag1,
  output logic [PTAG_W-1:0] released_tag2,
  output logic              released_tag1_val,
  output logic              released_tag2_val,
  output logic [1:0]        relnum,
  output logic              full,
  output logic              recovering
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] TWO     = (AW+1)'(2);

  typedef struct packed {
    logic              wr;
    logic [PTAG_W-1:0] old_tag;
    logic [PTAG_W-1:0] new_tag;
  } entry_t;

  entry_t mem [DEPTH];

  rq_state_e   state_q, state_nxt;
  logic [AW-1:0] head_q, head_nxt, tail_q, tail_nxt, wi2;
  logic [AW:0]   count_q, count_nxt, after_cmt, walk;
  logic          we1, we2;
  logic          a_val, b_val;
  logic [PTAG_W-1:0] a_tag, b_tag;
  logic [PTAG_W-1:0] c_tag1, c_tag2;
  logic          c_val1, c_val2;
  logic [1:0]    c_relnum;

  always_comb begin
    state_nxt = state_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    count_nxt = count_q;
    we1       = 1'b0;
    we2       = 1'b0;
    wi2       = tail_q;
    a_val     = 1'b0;
    a_tag     = '0;
    b_val     = 1'b0;
    b_tag     = '0;
    walk      = '0;
    after_cmt = count_q - (AW+1)'(comnum);
    unique case (state_q)
      RQ_IDLE: begin
        a_val    = (comnum != 2'd0) && mem[head_q].wr;
        a_tag    = mem[head_q].old_tag;
        b_val    = comnum[1] && mem[head_q + AW'(1)].wr;
        b_tag    = mem[head_q + AW'(1)].old_tag;
        head_nxt = head_q + AW'(comnum);
        count_nxt = after_cmt;
        // Commit in the prmiss cycle is older than the squash, so it still retires.
        if (prmiss) begin
          if (after_cmt != '0) state_nxt = RQ_RECOVER;
        end else if (!stall_DP && !full) begin
          we1       = disp_en1;
          we2       = disp_en2;
          wi2       = disp_en1 ? tail_q + AW'(1) : tail_q;
          tail_nxt  = tail_q + AW'(disp_en1) + AW'(disp_en2);
          count_nxt = after_cmt + (AW+1)'(disp_en1) + (AW+1)'(disp_en2);
        end
      end
      RQ_RECOVER: begin
        a_val     = (count_q != '0) && mem[tail_q - AW'(1)].wr;
        a_tag     = mem[tail_q - AW'(1)].new_tag;
        b_val     = (count_q >= TWO) && mem[tail_q - AW'(2)].wr;
        b_tag     = mem[tail_q - AW'(2)].new_tag;
        walk      = (count_q >= TWO) ? TWO : count_q;
        tail_nxt  = tail_q - AW'(walk);
        count_nxt = count_q - walk;
        if (count_nxt == '0) state_nxt = RQ_IDLE;
      end
      default: state_nxt = RQ_IDLE;
    endcase
  end

  rel_compact #(.PTAG_W(PTAG_W)) u_rel_compact (
    .a_val  (a_val),
    .a_tag  (a_tag),
    .b_val  (b_val),
    .b_tag  (b_tag),
    .tag1   (c_tag1),
    .tag2   (c_tag2),
    .val1   (c_val1),
    .val2   (c_val2),
    .relnum (c_relnum)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= RQ_IDLE;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      released_tag1     <= '0;
      released_tag2     <= '0;
      released_tag1_val <= 1'b0;
      released_tag2_val <= 1'b0;
      relnum            <= '0;
      full              <= 1'b0;
      recovering        <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      head_q            <= head_nxt;
      tail_q            <= tail_nxt;
      count_q           <= count_nxt;
      released_tag1     <= c_tag1;
      released_tag2     <= c_tag2;
      released_tag1_val <= c_val1;
      released_tag2_val <= c_val2;
      relnum            <= c_relnum;
      full              <= count_nxt > FULL_TH;
      recovering        <= state_nxt == RQ_RECOVER;
    end
  end

  always_ff @(posedge clk) begin
    if (we1) mem[tail_q] <= '{wr: disp_wr1, old_tag: disp_old_tag1, new_tag: disp_new_tag1};
    if (we2) mem[wi2]    <= '{wr: disp_wr2, old_tag: disp_old_tag2, new_tag: disp_new_tag2};
  end

endmodule

// File: tb/tb_commit_release_queue.sv
// Bench for commit_release_queue against a queue-based model of commit, push and squash.
module tb_commit_release_queue;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned PTAG_W = 6;
  localparam int unsigned OW     = 2*PTAG_W + 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              disp_en1, disp_en2, disp_wr1, disp_wr2;
  logic [PTAG_W-1:0] disp_old_tag1, disp_old_tag2, disp_new_tag1, disp_new_tag2;
  logic              stall_DP, prmiss;
  logic [1:0]        comnum;
  logic [PTAG_W-1:0] released_tag1, released_tag2;
  logic              released_tag1_val, released_tag2_val;
  logic [1:0]        relnum;
  logic              full, recovering;

  commit_release_queue #(.DEPTH(DEPTH), .PTAG_W(PTAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_en1(disp_en1), .disp_en2(disp_en2), .disp_wr1(disp_wr1), .disp_wr2(disp_wr2),
    .disp_old_tag1(disp_old_tag1), .disp_old_tag2(disp_old_tag2),
    .disp_new_tag1(disp_new_tag1), .disp_new_tag2(disp_new_tag2),
    .stall_DP(stall_DP), .comnum(comnum), .prmiss(prmiss),
    .released_tag1(released_tag1), .released_tag2(released_tag2),
    .released_tag1_val(released_tag1_val), .released_tag2_val(released_tag2_val),
    .relnum(relnum), .full(full), .recovering(recovering)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic              wr;
    logic [PTAG_W-1:0] o;
    logic [PTAG_W-1:0] n;
  } ent_t;

  ent_t q[$];
  bit   m_rec  = 1'b0;
  bit   m_full = 1'b0;
  logic [OW-1:0] exp_v;
  logic [OW-1:0] obs;

  assign obs = {released_tag1, released_tag2, released_tag1_val, released_tag2_val,
                relnum, full, recovering};

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(full && !recovering && !stall_DP && !prmiss && (disp_en1 || disp_en2)));

  function automatic logic [PTAG_W-1:0] rt();
    return PTAG_W'($urandom);
  endfunction

  // Reference: commit pops the front, squash pops the back, pushes append.
  task automatic model_edge();
    logic [PTAG_W-1:0] rl[$];
    ent_t e;
    if (!reset_n) begin
      q.delete();
      m_rec = 1'b0;
    end else if (!m_rec) begin
      for (int k = 0; k < int'(comnum); k++)
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e.wr) rl.push_back(e.o);
        end
      if (prmiss) m_rec = (q.size() > 0);
      else if (!stall_DP && !m_full) begin
        if (disp_en1) q.push_back('{disp_wr1, disp_old_tag1, disp_new_tag1});
        if (disp_en2) q.push_back('{disp_wr2, disp_old_tag2, disp_new_tag2});
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (q.size() > 0) begin
          e = q.pop_back();
          if (e.wr) rl.push_back(e.n);
        end
      if (q.size() == 0) m_rec = 1'b0;
    end
    m_full = q.size() > DEPTH - 2;
    exp_v = {(rl.size() > 0) ? rl[0] : PTAG_W'(0), (rl.size() > 1) ? rl[1] : PTAG_W'(0),
             rl.size() > 0, rl.size() > 1, 2'(rl.size()), m_full, m_rec};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e1, input logic w1, input logic [PTAG_W-1:0] o1,
                       input logic [PTAG_W-1:0] n1, input logic e2, input logic w2,
                       input logic [PTAG_W-1:0] o2, input logic [PTAG_W-1:0] n2,
                       input logic [1:0] cn);
    disp_en1 = e1; disp_wr1 = w1; disp_old_tag1 = o1; disp_new_tag1 = n1;
    disp_en2 = e2; disp_wr2 = w2; disp_old_tag2 = o2; disp_new_tag2 = n2;
    comnum = cn; stall_DP = 1'b0; prmiss = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (m_rec) idle();
      else if (q.size() > 0) drive(0, 0, '0, '0, 0, 0, '0, '0, (q.size() > 1) ? 2'd2 : 2'd1);
      else break;
      tick();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL drain obs=%h exp=%h", obs, exp_v); end
    end
    idle();
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL drain_tail obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 1, 6'd3, 6'd33, 0, 0, '0, '0, 2'd0);
    tick();
    checks++;
    if (obs !== {OW{1'b0}}) begin failures++; $display("FAIL reset_outputs obs=%h exp=0", obs); end
    reset_n = 1'b1;
    idle();
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_release obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_commit_pair();
    drive(1, 1, 6'd5, 6'd40, 1, 1, 6'd6, 6'd41, 2'd0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd2);
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL commit_pair obs=%h exp=%h", obs, exp_v); end
    checks++;
    if ({released_tag1, released_tag2, relnum} !== {6'd5, 6'd6, 2'd2}) begin
      failures++;
      $display("FAIL commit_pair_tags got=%0d,%0d,%0d want=5,6,2", released_tag1, released_tag2, relnum);
    end
    idle();
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL commit_hold obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_compaction();
    drive(1, 0, 6'd7, 6'd50, 1, 1, 6'd9, 6'd51, 2'd0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd2);
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL compaction obs=%h exp=%h", obs, exp_v); end
    checks++;
    if ({released_tag1, released_tag1_val, released_tag2_val, relnum} !== {6'd9, 1'b1, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL compaction_slot1 got tag=%0d v2=%b relnum=%0d want 9,0,1",
               released_tag1, released_tag2_val, relnum);
    end
    // Lone slot 2 push must land at tail.
    drive(0, 0, '0, '0, 1, 1, 6'd12, 6'd52, 2'd0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd1);
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL lone_slot2 obs=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1'($urandom), rt(), rt(), 1, 1'($urandom), rt(), rt(), 2'd0);
      tick();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL fill%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (full !== 1'b0) begin failures++; $display("FAIL full_at_30 got=%b want=0", full); end
    drive(1, 1, rt(), rt(), 0, 0, '0, '0, 2'd0);
    tick();
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL full_at_31 got=%b want=1", full); end
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd2);
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL unfull obs=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 40; i++) begin
      drive(1, 1'($urandom), rt(), rt(), 1, 1'($urandom), rt(), rt(), 2'd2);
      tick();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL stream%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    drain();
  endtask

  task automatic test_recovery();
    int n_rec;
    logic [PTAG_W-1:0] first_old;
    first_old = rt();
    drive(1, 1, first_old, 6'd40, 1, 1, rt(), 6'd41, 2'd0);
    tick();
    drive(1, 1, rt(), 6'd42, 1, 1, rt(), 6'd43, 2'd0);
    tick();
    drive(1, 1, rt(), 6'd44, 1, 1, rt(), 6'd45, 2'd0);
    tick();
    drive(1, 1, rt(), 6'd46, 1, 1, rt(), 6'd47, 2'd1);
    prmiss = 1'b1;
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL prmiss_cycle obs=%h exp=%h", obs, exp_v); end
    checks++;
    if ({released_tag1, relnum} !== {first_old, 2'd1}) begin
      failures++;
      $display("FAIL prmiss_commit got=%0d/%0d want=%0d/1", released_tag1, relnum, first_old);
    end
    n_rec = recovering ? 1 : 0;
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (recovering) n_rec++;
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL walk%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (n_rec != 3) begin failures++; $display("FAIL recover_len got=%0d want=3", n_rec); end
  endtask

  task automatic test_reset_mid_recovery();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, rt(), PTAG_W'(40 + 2*i), 1, 1, rt(), PTAG_W'(41 + 2*i), 2'd0);
      tick();
    end
    idle();
    prmiss = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL walk_first obs=%h exp=%h", obs, exp_v); end
    reset_n = 1'b0;
    tick();
    checks++;
    if (obs !== {OW{1'b0}}) begin failures++; $display("FAIL mid_reset obs=%h exp=0", obs); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL post_reset%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    drive(1, 1, 6'd21, 6'd22, 0, 0, '0, '0, 2'd0);
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 2'd1);
    tick();
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL post_reset_commit obs=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_random();
    int maxc;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), rt(), rt(), 1'($urandom), 1'($urandom), rt(), rt(), 2'd0);
      stall_DP = ($urandom_range(0, 5) == 0);
      prmiss   = ($urandom_range(0, 19) == 0);
      if (m_full) begin disp_en1 = 1'b0; disp_en2 = 1'b0; end
      if (!m_rec) begin
        maxc = (q.size() > 2) ? 2 : q.size();
        comnum = 2'($urandom_range(0, maxc));
      end
      tick();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 1'b0;
    #1;
    test_reset();
    test_commit_pair();
    test_compaction();
    test_full_wrap();
    test_recovery();
    test_reset_mid_recovery();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
